// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared constants for the multiply sequencer: FSM encodings, settle-window
// default and HI/LO register widths.
package mul_hilo_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned MUL_CYCLES_DEF = 2;
    localparam int unsigned OP_W           = 32;
    localparam int unsigned HI_W           = 32;
    localparam int unsigned LO_W           = 32;
    localparam int unsigned PROD_W         = HI_W + LO_W;

endpackage

// File: rtl/mul_hilo_ctrl_booth.sv
// Combinational radix-2 Booth multiplier: signed 32x32 -> 64 product.
module boothMultiplier
    import mul_hilo_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] ext_a;
    logic [PROD_W-1:0] acc;
    logic              prev;

    assign ext_a = {{(PROD_W-OP_W){a[OP_W-1]}}, a};

    // Each bit pair {b[i], b[i-1]} selects +a, -a or nothing at weight 2^i.
    always_comb begin
        acc  = '0;
        prev = 1'b0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            case ({b[i], prev})
                2'b10:   acc = acc - (ext_a << i);
                2'b01:   acc = acc + (ext_a << i);
                default: acc = acc;
            endcase
            prev = b[i];
        end
        product = acc;
    end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multiply sequencer: latches operands, holds them on the Booth multiplier for
// MUL_CYCLES cycles, captures the product into HI/LO and pulses done.
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    input  logic            hi_wr,
    input  logic [HI_W-1:0] hi_in,
    input  logic            lo_wr,
    input  logic [LO_W-1:0] lo_in,
    output logic            busy,
    output logic            done,
    output logic [HI_W-1:0] hi,
    output logic [LO_W-1:0] lo
);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [OP_W-1:0]   ra, rb;
    logic [PROD_W-1:0] product;
    logic              load, capture;

    boothMultiplier u_booth (
        .a       (ra),
        .b       (rb),
        .product (product)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    cnt_nx   = 4'(MUL_CYCLES - 1);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= capture;
            if (load) begin
                ra <= op_a;
                rb <= op_b;
            end
            // Product capture takes priority over a same-edge direct write.
            if (capture) begin
                hi <= product[PROD_W-1:LO_W];
                lo <= product[LO_W-1:0];
            end else begin
                if (hi_wr) hi <= hi_in;
                if (lo_wr) lo <= lo_in;
            end
        end
    end

    assign busy = (state == WAIT);

endmodule
